// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between datapath and data-memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_word_we;
  logic        req_byte_we;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_word_we, req_byte_we, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_word_we, req_byte_we, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder: one access in flight, fixed latency, word/byte stores
module dmem_responder #(
  parameter int WORDS   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic          word_we_q, byte_we_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          capture, commit;
  logic [31:0]   mem_q [WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          in_range;
  logic [31:0]   cur_word, new_word, lane_mask, lane_data;

  assign idx       = addr_q[AW+1:2];
  assign lane      = addr_q[1:0];
  assign in_range  = (addr_q >> (AW + 2)) == 32'd0;
  assign cur_word  = mem_q[idx];
  assign lane_mask = 32'h0000_00ff << {lane, 3'b000};
  assign lane_data = {24'd0, wdata_q[7:0]} << {lane, 3'b000};

  // Word store wins over byte store; neither means the word is left as is.
  always_comb begin
    new_word = cur_word;
    if (word_we_q) begin
      new_word = wdata_q;
    end else if (byte_we_q) begin
      new_word = (cur_word & ~lane_mask) | lane_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          commit  = 1'b1;
          rdata_d = in_range ? new_word : 32'd0;
          err_d   = ~in_range;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_we_q <= 1'b0;
      byte_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q    <= bus.req_addr;
        wdata_q   <= bus.req_wdata;
        word_we_q <= bus.req_word_we;
        byte_we_q <= bus.req_byte_we;
      end
    end
  end

  // Reset wipes the whole array so a dropped store can never become visible.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && in_range && (word_we_q || byte_we_q)) begin
      mem_q[idx] <= new_word;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the slave end of the load/store interface driven by the processor datapath. Accepts one word-store, byte-store or word-load request at a time over a valid/ready handshake, holds it for a programmable access latency, commits it to an internal word array, then returns a response (read data plus error flag) over a second valid/ready handshake. It replaces the single-cycle data memory when the processor is built with stall support.

## Interface

- WORDS, 256, depth of the storage array in 32-bit words; power of two, at least 4.
- LATENCY, 2, cycles from request acceptance to response; must be at least 1.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte stores use [7:0].
- req_word_we  in  1  word store.
- req_byte_we  in  1  byte store.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  word at the addressed location after the access.
- resp_err  out  1  address out of range.

## Operation

- Addressing:
  - Word index is req_addr[log2(WORDS)+1:2]. Lane is req_addr[1:0].
  - Lane 0 is bits [7:0]; lane 3 is bits [31:24].
  - Word operations ignore addr[1:0].
  - In range means req_addr < 4*WORDS. Any higher bit set gives an error.
- Operation select:
  - req_word_we has priority over req_byte_we.
  - Neither asserted means a load.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, capture addr, wdata and both enables. Load cnt=LATENCY-1 and go to WAIT.
  - WAIT: req_ready=0. If cnt≠0, decrement cnt. If cnt=0, commit the access and go to RESP.
    - Word store writes the whole word.
    - Byte store writes only the addressed lane with wdata[7:0].
    - resp_rdata gets the post-commit word. Loads are unchanged, so this is the current word.
    - Out-of-range access: no write, resp_rdata=0, resp_err=1.
  - RESP: resp_valid=1, req_ready=0. resp_rdata and resp_err hold stable until resp_ready=1, then go to IDLE. The next request can be accepted no earlier than the cycle after that.
- resp_err is 0 for every in-range access.
- Input changes while not in IDLE are ignored.

## Timing

- All outputs are registered or decoded from state. There are no combinational paths from inputs to outputs.
- Reset (reset=0 at a rising edge), which also applies mid-operation:
  - State goes to IDLE and cnt to 0.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 from the following cycle.
  - Every array word is cleared to 0.
  - An in-flight access that has not yet committed is dropped. A pending response is discarded.
- Latency:
  - Request accepted at edge E0 (state IDLE, req_valid=1).
  - Commit occurs at edge E0+LATENCY.
  - resp_valid is high from the cycle after edge E0+LATENCY.
  - Minimum handshake period is LATENCY+2 edges when resp_ready is held at 1.
- Back-to-back requests:
  - A store followed by a load to the same address returns the stored data.
  - There is no forwarding requirement, because accesses never overlap.
- Byte lanes:
  - Byte stores to the four lanes of one word are independent.
  - Lane 3 of word WORDS-1 (address 4*WORDS-1) is in range.
  - Address 4*WORDS is out of range.

## Test plan

- Reset, then word store: store addr 0x10, wdata 0xDEADBEEF, LATENCY=2, accept at E0. Then load 0x10.
  - resp_valid first high after E2.
  - Both responses read 0xDEADBEEF with resp_err=0.
- Byte store lane merge: word store 0x20 = 0x11223344, then byte store 0x22 with wdata 0x000000AB.
  - Response rdata 0x11AB3344.
  - A load of 0x23 returns 0x11AB3344.
- Response backpressure: hold resp_ready=0 for 5 cycles after a load response appears.
  - resp_valid, resp_rdata and resp_err stay stable.
  - req_ready=0 throughout, and a req_valid presented during that time is not accepted.
  - After resp_ready=1 for one cycle, req_ready=1.
- Out of range (WORDS=256): store 0x400 = 0xFFFFFFFF.
  - resp_err=1, rdata=0.
  - A load of 0x0 still returns 0.
  - A store to 0x3FF with byte_we, wdata 0x5A is in range: rdata 0x5A000000, err 0.
- Reset mid-operation: accept a word store 0x8 = 0x1234, assert reset=0 during WAIT before the commit edge.
  - Next cycle: req_ready=1, resp_valid=0.
  - A subsequent load of 0x8 returns 0.
- Priority and latency corner: LATENCY=1, request with req_word_we=1 and req_byte_we=1, addr 0x5, wdata 0xCAFEF00D.
  - Full word at 0x4 is written as 0xCAFEF00D.
  - resp_valid is high in the cycle after E1.
